fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-side controller for the FIFO: consumes the FIFO status flags, issues `fifo_rd` in bursts, captures read data returned one cycle later, and presents it downstream over a valid/ready interface through a 2-entry output buffer. It sits between the FIFO memory/control pair and the downstream consumer and guarantees the FIFO never sees a read while empty.

## Interface
- `WORD_SIZE`, 10: data word width in bits.
- `PTR`, 3: FIFO pointer width; burst length field width.

- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `fifo_empty`  in  1: FIFO empty flag; reflects all reads up to the previous cycle.
- `fifo_almost_empty`  in  1: FIFO at/below its empty threshold.
- `fifo_data`  in  WORD_SIZE: read data, valid the cycle after `fifo_rd`.
- `flush`  in  1: start a burst even while `fifo_almost_empty`=1.
- `burst_len`  in  PTR: words per burst; 0 means 2^PTR. Sampled on IDLE→BURST.
- `fifo_rd`  out  1: read strobe to FIFO (combinational).
- `out_data`  out  WORD_SIZE: head of output buffer.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: downstream accepts when `out_valid`&`out_ready`.
- `burst_done`  out  1: one-cycle pulse when a burst fully drains.

## Operation
- State machine IDLE, BURST, DRAIN.
- IDLE → BURST when `fifo_empty`=0 and (`fifo_almost_empty`=0 or `flush`=1); latch burst target (PTR+1 bits), clear read counter. No read in the transition cycle.
- BURST: `fifo_rd` = `fifo_empty`=0 and (occ + inflight − pop) ≤ 1, where occ = buffer entries (0..2), inflight = read issued last cycle (0/1), pop = `out_valid`&`out_ready`. Each `fifo_rd` increments read counter.
- BURST → DRAIN when read counter reaches target on this cycle's read, or `fifo_empty`=1 with no read this cycle.
- DRAIN: no reads; → IDLE when occ=0 and inflight=0; `burst_done`=1 in the cycle of that transition.
- Buffer: inflight data written at tail the cycle after `fifo_rd`; pop removes head; simultaneous write and pop allowed at any occupancy ≤2. Order strictly FIFO.
- `fifo_rd` never asserted while `fifo_empty`=1 or outside BURST; buffer can never overflow.
- `out_data` holds steady while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values: state IDLE, occ 0, inflight 0, `fifo_rd` 0, `out_valid` 0, `out_data` 0, `burst_done` 0.
- Reset mid-burst: in-flight and buffered words discarded; next cycle is IDLE.
- Latency: `fifo_rd` in cycle t → `fifo_data` sampled end of t+1 → `out_valid`=1 in t+2 (if buffer was empty).
- With `out_ready` held 1 and FIFO not empty: one read per cycle sustained after the first.
- `out_ready`=0: at most 2 reads issue, then `fifo_rd` stays 0 until a pop.
- `burst_len`=0: exactly 8 reads (PTR=3).

## Structure
- Shared package: state enum (IDLE/BURST/DRAIN), buffer depth constant 2, burst target width PTR+1.
- Sub-module `rd_skid_buffer`: 2-entry valid/ready buffer (occ, head/tail, push/pop); FSM and read counter stay in the top.

## Test plan
- FIFO holds 5, `fifo_almost_empty`=0, `burst_len`=3, `out_ready`=1 → 3 consecutive `fifo_rd`, 3 words out in order 2 cycles later, one `burst_done`, back to IDLE.
- `flush`=1, `fifo_almost_empty`=1, FIFO holds 2, `burst_len`=4 → 2 reads, BURST→DRAIN on empty, `burst_done` after both words popped; no read while empty.
- `out_ready`=0 during burst of 6 → exactly 2 reads, `out_data` stable; release `out_ready` → remaining 4 read, all 6 delivered in order.
- `burst_len`=0, FIFO holds 8, `out_ready`=1 → exactly 8 reads, counter no wrap.
- Reset asserted one cycle after second `fifo_rd` → next cycle `out_valid`=0, `fifo_rd`=0, state IDLE; no stale word delivered after reset.
- Toggle `out_ready` randomly over 20-word traffic → sequence matches FIFO contents, occ never >2.

Source files
------------

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_read_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Output buffer depth; the read throttle in the top relies on this being 2.
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    // Burst target needs one extra bit so that a burst of 2^PTR words is representable.
    function automatic int tgt_width(input int ptr);
        return ptr + 1;
    endfunction

endpackage

// File: rtl/rd_skid_buffer.sv
// Two-entry valid/ready output buffer. Words pushed at the tail, head drives the
// output; a push and a pop may happen in the same cycle at any occupancy.
module rd_skid_buffer
    import fifo_read_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    output logic [OCC_W-1:0]     occ
);

    logic [WORD_SIZE-1:0] mem_q [BUF_DEPTH];
    logic [WORD_SIZE-1:0] mem_d [BUF_DEPTH];
    logic                 head_q, head_d;
    logic                 tail_q, tail_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 pop;

    assign out_valid = (occ_q != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_q[head_q];
    assign occ       = occ_q;

    // Next buffer contents and pointers. When full, tail equals head, so a
    // push with a simultaneous pop overwrites exactly the entry leaving.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    // Buffer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read-side controller: issues bursts of reads, captures the returned
// words into a 2-entry output buffer and presents them over valid/ready.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for enough FIFO data (or flush); no reads
//   ST_BURST | issuing reads while the buffer has room, until target or empty
//   ST_DRAIN | no reads; waiting for in-flight and buffered words to leave
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 10,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    input  logic                 fifo_almost_empty,
    input  logic [WORD_SIZE-1:0] fifo_data,
    input  logic                 flush,
    input  logic [PTR-1:0]       burst_len,
    output logic                 fifo_rd,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 burst_done
);

    localparam int TGT_W = tgt_width(PTR);

    state_e           state_q, state_d;
    logic [TGT_W-1:0] cnt_q, cnt_d;
    logic [TGT_W-1:0] tgt_q, tgt_d;
    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic [2:0]       load;
    logic             room;

    rd_skid_buffer #(
        .WORD_SIZE (WORD_SIZE)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (fifo_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .occ       (occ)
    );

    // A new read is allowed only if the word it returns is guaranteed a slot.
    assign pop  = out_valid & out_ready;
    assign load = 3'(occ) + 3'(inflight_q);
    assign room = (load <= (3'd1 + 3'(pop)));

    // Next-state, burst bookkeeping and read strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        fifo_rd    = 1'b0;
        burst_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (!fifo_almost_empty || flush)) begin
                    state_d = ST_BURST;
                    cnt_d   = '0;
                    tgt_d   = (burst_len == '0) ? (TGT_W'(1) << PTR) : TGT_W'(burst_len);
                end
            end
            ST_BURST: begin
                fifo_rd = !fifo_empty && room;
                if (fifo_rd) begin
                    cnt_d = cnt_q + TGT_W'(1);
                    if (cnt_d == tgt_q) begin
                        state_d = ST_DRAIN;
                    end
                end else if (fifo_empty) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ == '0 && !inflight_q) begin
                    state_d    = ST_IDLE;
                    burst_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Keep the FIFO untouched and suppress the pulse while reset is held.
        if (reset) begin
            fifo_rd    = 1'b0;
            burst_done = 1'b0;
        end
        inflight_d = fifo_rd;
    end

    // Controller state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tgt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: table-driven burst scenarios, a
// reset-mid-burst sequence and randomized traffic against a transaction model.
module tb_fifo_read_ctrl;

    localparam int WS  = 10;
    localparam int PTR = 3;

    logic          clk;
    logic          reset;
    logic          fifo_empty;
    logic          fifo_almost_empty;
    logic [WS-1:0] fifo_data;
    logic          flush;
    logic [PTR-1:0] burst_len;
    logic          fifo_rd;
    logic [WS-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          burst_done;

    fifo_read_ctrl #(.WORD_SIZE(WS), .PTR(PTR)) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty        (fifo_empty),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_data         (fifo_data),
        .flush             (flush),
        .burst_len         (burst_len),
        .fifo_rd           (fifo_rd),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .burst_done        (burst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // FIFO contents and reference model: every read word is owed downstream,
    // in read order, no earlier than two cycles after its read.
    logic [WS-1:0] fifo_q[$];
    logic [WS-1:0] exp_q[$];
    int            rd_cyc_q[$];
    int            cyc        = 0;
    int            rd_total   = 0;
    int            done_total = 0;
    int            pop_total  = 0;
    logic          prev_stall = 1'b0;
    logic [WS-1:0] prev_data  = '0;
    bit            ae_auto    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        logic rd;
        logic rst_now;
        bit   exp_valid;
        @(negedge clk);
        rd      = fifo_rd;
        rst_now = reset;
        exp_valid = (rd_cyc_q.size() > 0) && (rd_cyc_q[0] <= cyc - 2);
        check("out_valid", int'(out_valid), int'(exp_valid));
        if (prev_stall) check("out_data_hold", int'(out_data), int'(prev_data));
        if (out_valid && out_ready && exp_q.size() > 0) begin
            check("out_data_order", int'(out_data), int'(exp_q[0]));
            void'(exp_q.pop_front());
            void'(rd_cyc_q.pop_front());
            pop_total++;
        end
        if (rd) begin
            rd_total++;
            check("rd_while_empty", int'(fifo_empty), 0);
            if (fifo_q.size() > 0) begin
                exp_q.push_back(fifo_q[0]);
                rd_cyc_q.push_back(cyc);
            end
            check("outstanding_le2", int'(rd_cyc_q.size() <= 2), 1);
        end
        if (burst_done) begin
            done_total++;
            check("done_outstanding", rd_cyc_q.size(), 0);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        cyc++;
        if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        if (rst_now) begin
            exp_q.delete();
            rd_cyc_q.delete();
            prev_stall = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0);
        if (ae_auto) fifo_almost_empty = (fifo_q.size() <= 2);
    endtask

    task automatic start(input int words, input int base);
        fifo_q.delete();
        for (int i = 0; i < words; i++) fifo_q.push_back(WS'(base + i));
        fifo_empty = (fifo_q.size() == 0);
        reset      = 1'b1;
        cycle();
        reset      = 1'b0;
    endtask

    typedef struct {
        int       words;
        bit       ae;
        bit       fl;
        int       blen;
        int       stall;
        int       exp_reads;
        int       exp_done;
        int       exp_stall_reads;
    } scn_t;

    scn_t tbl[6];

    initial begin
        int rd0, d0, p0, stall_rd;
        reset = 1'b1; fifo_empty = 1'b1; fifo_almost_empty = 1'b1; fifo_data = '0;
        flush = 1'b0; burst_len = '0; out_ready = 1'b0;

        // Reset state.
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_fifo_rd", int'(fifo_rd), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_burst_done", int'(burst_done), 0);
        @(posedge clk); #1;

        //          words ae fl blen stall reads done stall_reads
        tbl[0] = '{5, 1'b0, 1'b0, 3, 0, 3, 1, 0};
        tbl[1] = '{2, 1'b1, 1'b1, 4, 0, 2, 1, 0};
        tbl[2] = '{8, 1'b0, 1'b0, 0, 0, 8, 1, 0};
        tbl[3] = '{6, 1'b0, 1'b0, 6, 8, 6, 1, 2};
        tbl[4] = '{3, 1'b1, 1'b0, 2, 0, 0, 0, 0};
        tbl[5] = '{1, 1'b0, 1'b0, 1, 4, 1, 1, 2};
        // Single-word burst stalled: only one read is possible, so the stall
        // window sees exactly one read.
        tbl[5].exp_stall_reads = 1;

        for (int k = 0; k < 6; k++) begin
            fifo_almost_empty = tbl[k].ae;
            flush             = tbl[k].fl;
            burst_len         = PTR'(tbl[k].blen);
            out_ready         = 1'b0;
            start(tbl[k].words, 100 * (k + 1));
            rd0 = rd_total; d0 = done_total; p0 = pop_total; stall_rd = 0;
            for (int n = 0; n < 60; n++) begin
                out_ready = (n >= tbl[k].stall);
                cycle();
                if (n == tbl[k].stall - 1) stall_rd = rd_total - rd0;
                if (done_total > d0) break;
            end
            check($sformatf("s%0d_reads", k), rd_total - rd0, tbl[k].exp_reads);
            check($sformatf("s%0d_burst_done", k), done_total - d0, tbl[k].exp_done);
            check($sformatf("s%0d_delivered", k), pop_total - p0, tbl[k].exp_reads);
            if (tbl[k].stall > 0)
                check($sformatf("s%0d_stall_reads", k), stall_rd, tbl[k].exp_stall_reads);
        end

        // Reset one cycle after the second read of a burst.
        fifo_almost_empty = 1'b0; flush = 1'b0; burst_len = 3'd6; out_ready = 1'b1;
        start(6, 700);
        rd0 = rd_total;
        for (int n = 0; n < 20 && (rd_total - rd0) < 2; n++) cycle();
        check("rst_seq_two_reads", rd_total - rd0, 2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #3;
        check("rst_seq_out_valid", int'(out_valid), 0);
        check("rst_seq_fifo_rd", int'(fifo_rd), 0);
        check("rst_seq_state_idle", int'(dut.state_q), 0);
        d0 = done_total; p0 = pop_total;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (done_total > d0) break;
        end
        check("rst_seq_done", done_total - d0, 1);
        check("rst_seq_delivered", pop_total - p0, 4);

        // Randomized traffic: 20 words, random ready/flush/burst length.
        fifo_q.delete();
        for (int i = 0; i < 20; i++) fifo_q.push_back(WS'($urandom_range(0, 1023)));
        ae_auto = 1'b1;
        fifo_almost_empty = (fifo_q.size() <= 2);
        fifo_empty = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        p0 = pop_total;
        for (int n = 0; n < 400 && (pop_total - p0) < 20; n++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = $urandom_range(0, 1) != 0;
            burst_len = PTR'($urandom_range(0, 7));
            cycle();
        end
        check("rand_delivered", pop_total - p0, 20);
        check("rand_fifo_drained", fifo_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
